key_step_conditioner: RTL and testbench
=======================================

// Module: key_step_conditioner
// PURPOSE
//  Upstream input stage for the ALU/accumulator datapath. It turns the raw, bouncy,
//  active-low push-buttons into clean control for the accumulator register:
//   - step: a single-cycle load-enable pulse, one per debounced press of key_n[0].
//   - func: the ALU function code, captured on the same cycle as the step.
//  The accumulator register then runs on the system clock and loads on step, instead of
//  being clocked directly by a button.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  stable cycles needed to accept a press or a release (>=2; 5 ms @ 50 MHz)
//  REPEAT_CYCLES    0       auto-repeat period while held; 0 = auto-repeat disabled
//  CNT_W            20      width of the debounce/repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES)
// PORTS
//  clock_in     in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  key_n        in   4  raw push-buttons, active-low; [0]=step key, [3:1]=function keys
//  step         out  1  one-cycle pulse; drives the accumulator load enable
//  func         out  3  ALU function code captured at the last step (raw synchronized key_n[3:1] levels)
//  press_count  out  8  number of steps issued; wraps modulo 256
//  state_dbg    out  2  current FSM state (IDLE=0, ARMING=1, HELD=2, RELEASING=3)
// BEHAVIOUR
//  Reset (asynchronous, active-high). Takes effect immediately, including mid-press:
//   - state=IDLE, step=0, func=3'b111, press_count=0, all counters=0, synchronizer FFs=1 (released).
//   - No step is emitted on reset deassertion, even if key_n[0] is held low at that time.
//  Synchronizer: 2-flop synchronizer on every key_n bit. "pressed" = synchronized key_n[0]==0.
//  FSM (one transition per clock_in edge):
//   IDLE:
//    - pressed -> ARMING, cnt=0.
//   ARMING:
//    - !pressed -> IDLE (bounce rejected, no step).
//    - pressed and cnt==DEBOUNCE_CYCLES-1 -> HELD; same edge: step=1, func<=sync key_n[3:1],
//      press_count++, rpt=0.
//    - otherwise cnt++.
//   HELD:
//    - !pressed -> RELEASING, cnt=0.
//    - REPEAT_CYCLES!=0 and rpt==REPEAT_CYCLES-1 -> step=1, func re-captured, press_count++, rpt=0.
//    - REPEAT_CYCLES!=0 otherwise -> rpt++.
//    - REPEAT_CYCLES==0 -> no further steps while held.
//   RELEASING:
//    - pressed -> HELD, rpt=0, no step (release bounce rejected).
//    - cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//    - otherwise cnt++.
//  step is registered and is high for exactly one cycle per issue; it is never high on two
//  consecutive cycles.
//  Latency, clean steady press: step goes high after the edge DEBOUNCE_CYCLES+2 edges after the
//  first edge that samples key_n[0] low (2 edges of synchronizer, 1 edge IDLE->ARMING, then the
//  DEBOUNCE_CYCLES-1 count in ARMING).
//  func changes only on a step cycle; between steps it holds its value, regardless of the
//  function keys.
//  press_count: 8-bit unsigned, 255 -> 0 wrap, no saturation and no flag.
//  Function-key changes coinciding with a step edge: func takes the synchronized value present
//  at that edge.
// TESTING (DEBOUNCE_CYCLES=4 unless noted)
//  1. Clean press: hold key_n=4'b1010 low on bit 0 for 20 cycles -> exactly one step, 6 edges
//     after the first low sample; func=3'b101; press_count=1.
//  2. Bounce: key_n[0] low 2 cycles, high 1, low 2, high -> no step, state_dbg returns to 0,
//     press_count=0.
//  3. Release bounce: after the step, key_n[0] high 2 cycles then low again, then high for 10
//     cycles -> no second step; state ends in IDLE.
//  4. Auto-repeat (REPEAT_CYCLES=8): hold 40 cycles after the first step -> further steps exactly
//     every 8 cycles; press_count increments on each.
//  5. Reset mid-ARMING: assert reset while state_dbg=1 -> outputs return to reset values at once;
//     key still held on deassertion -> no step until release and re-press.
//  6. Wrap: issue 256 presses -> press_count reads 0, and each step pulse is exactly 1 cycle wide.

Source files
------------

// File: rtl/key_step_conditioner.sv
// Debounces active-low buttons into a one-cycle accumulator load pulse plus a captured ALU function code.
// Latency: step rises DEBOUNCE_CYCLES+2 edges after key_n[0] is first sampled low; no backpressure.
module key_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int CNT_W           = 20
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic [3:0] key_n,
  output logic       step,
  output logic [2:0] func,
  output logic [7:0] press_count,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               RPT_EN   = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] RPT_LAST = RPT_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

  logic [3:0]       sync_a;
  logic [3:0]       sync_b;
  logic             pressed;
  logic [1:0]       fill_cnt;
  logic             need_release;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] rpt;
  logic [CNT_W-1:0] rpt_nxt;
  logic             issue;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_a <= 4'hF;
      sync_b <= 4'hF;
    end else begin
      sync_a <= key_n;
      sync_b <= sync_a;
    end
  end

  assign pressed = ~sync_b[0];

  // A key held through reset must be seen released (with real samples
  // in the synchronizer, not reset fill) before a new press can arm.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      fill_cnt     <= 2'd0;
      need_release <= 1'b1;
    end else if (fill_cnt != 2'd2) begin
      fill_cnt <= fill_cnt + 2'd1;
    end else if (!pressed) begin
      need_release <= 1'b0;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rpt_nxt   = rpt;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (pressed && !need_release) begin
          state_nxt = ARMING;
          cnt_nxt   = '0;
        end
      end
      ARMING: begin
        if (!pressed) begin
          state_nxt = IDLE;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          issue     = 1'b1;
          rpt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_nxt = RELEASING;
          cnt_nxt   = '0;
        end else if (RPT_EN) begin
          // Holding at the terminal count keeps a 1-cycle period from
          // producing back-to-back pulses.
          if (rpt == RPT_LAST) begin
            if (!step) begin
              issue   = 1'b1;
              rpt_nxt = '0;
            end
          end else begin
            rpt_nxt = rpt + CNT_W'(1);
          end
        end
      end
      RELEASING: begin
        if (pressed) begin
          state_nxt = HELD;
          rpt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      rpt         <= '0;
      step        <= 1'b0;
      func        <= 3'b111;
      press_count <= 8'd0;
    end else begin
      cnt  <= cnt_nxt;
      rpt  <= rpt_nxt;
      step <= issue;
      if (issue) begin
        func        <= sync_b[3:1];
        press_count <= press_count + 8'd1;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Bench for key_step_conditioner: two instances (no repeat / repeat every 8) share stimulus
// and are compared each cycle against an event-level model built on press/release run lengths.
module tb_key_step_conditioner;

  localparam int D  = 4;
  localparam int R1 = 8;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b0;
  logic [3:0] key_n    = 4'hF;

  logic       step0, step1;
  logic [2:0] func0, func1;
  logic [7:0] pc0, pc1;
  logic [1:0] st0, st1;

  always #5 clock_in = ~clock_in;

  key_step_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0), .CNT_W(8)) dut0 (
    .clock_in(clock_in), .reset(reset), .key_n(key_n),
    .step(step0), .func(func0), .press_count(pc0), .state_dbg(st0)
  );

  key_step_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R1), .CNT_W(8)) dut1 (
    .clock_in(clock_in), .reset(reset), .key_n(key_n),
    .step(step1), .func(func1), .press_count(pc1), .state_dbg(st1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] h0, h1;
  int         esr;
  bit         locked;
  int         now;
  bit         down[2];
  int         prun[2];
  int         rrun[2];
  int         anchor[2];
  logic [2:0] mfunc[2];
  logic [7:0] mcnt[2];
  logic       mstep[2];
  int         rep[2] = '{0, R1};

  int         tick_no = 0;
  logic       prev_step[2];
  int         nsteps[2];
  int         last_tick[2];

  task automatic model_reset();
    h0 = 4'hF; h1 = 4'hF; esr = 0; locked = 1'b1;
    for (int i = 0; i < 2; i++) begin
      down[i] = 1'b0; prun[i] = 0; rrun[i] = 0; anchor[i] = 0;
      mfunc[i] = 3'b111; mcnt[i] = 8'd0; mstep[i] = 1'b0;
      prev_step[i] = 1'b0;
    end
  endtask

  // One clock edge: p is the key level that has crossed the 2-stage synchronizer.
  task automatic model_edge();
    logic [3:0] s;
    bit p, real_s, ret;
    s = h1; h1 = h0; h0 = key_n;
    real_s = (esr >= 2);
    if (esr < 2) esr++;
    p = !s[0];
    now++;
    for (int i = 0; i < 2; i++) mstep[i] = 1'b0;
    if (locked) begin
      if (real_s && !p) locked = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (p) begin
          ret = down[i] && (rrun[i] > 0);
          rrun[i] = 0;
          prun[i]++;
          if (!down[i]) begin
            if (prun[i] == D + 1) begin
              mstep[i] = 1'b1; mfunc[i] = s[3:1]; mcnt[i]++;
              down[i] = 1'b1; anchor[i] = now;
            end
          end else if (ret) begin
            anchor[i] = now;
          end else if (rep[i] != 0 && now - anchor[i] == rep[i]) begin
            mstep[i] = 1'b1; mfunc[i] = s[3:1]; mcnt[i]++;
            anchor[i] = now;
          end
        end else begin
          prun[i] = 0;
          rrun[i]++;
          if (down[i] && rrun[i] == D + 1) down[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock_in);
    #1;
    tick_no++;
    check("step0", step0, mstep[0]);
    check("func0", func0, mfunc[0]);
    check("count0", pc0, mcnt[0]);
    check("step1", step1, mstep[1]);
    check("func1", func1, mfunc[1]);
    check("count1", pc1, mcnt[1]);
    check("pulse0_width", step0 & prev_step[0], 0);
    check("pulse1_width", step1 & prev_step[1], 0);
    prev_step[0] = step0;
    prev_step[1] = step1;
    if (step0) begin nsteps[0]++; last_tick[0] = tick_no; end
    if (step1) begin nsteps[1]++; last_tick[1] = tick_no; end
  endtask

  task automatic drive(input logic [3:0] k, input int n);
    key_n = k;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_step0", step0, 0);
    check("rst_func0", func0, 3'b111);
    check("rst_count0", pc0, 0);
    check("rst_state0", st0, 0);
    check("rst_step1", step1, 0);
    check("rst_func1", func1, 3'b111);
    check("rst_count1", pc1, 0);
    check("rst_state1", st1, 0);
    repeat (2) @(posedge clock_in);
    @(negedge clock_in);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] key;
    int         n;
    int         steps;
    logic [2:0] fn;
    logic [7:0] pc;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int t0, s0, s1, first, gap_bad;

    tbl[0]  = '{4'hF, 6,  0, 3'd7, 8'd0, 2'd0};
    tbl[1]  = '{4'hE, 2,  0, 3'd7, 8'd0, 2'd0};
    tbl[2]  = '{4'hF, 1,  0, 3'd7, 8'd0, 2'd1};
    tbl[3]  = '{4'hE, 2,  0, 3'd7, 8'd0, 2'd0};
    tbl[4]  = '{4'hF, 8,  0, 3'd7, 8'd0, 2'd0};
    tbl[5]  = '{4'hA, 20, 1, 3'd5, 8'd1, 2'd2};
    tbl[6]  = '{4'hF, 2,  0, 3'd5, 8'd1, 2'd2};
    tbl[7]  = '{4'hA, 3,  0, 3'd5, 8'd1, 2'd2};
    tbl[8]  = '{4'hF, 10, 0, 3'd5, 8'd1, 2'd0};
    tbl[9]  = '{4'h4, 12, 1, 3'd2, 8'd2, 2'd2};
    tbl[10] = '{4'hF, 12, 0, 3'd2, 8'd2, 2'd0};
    tbl[11] = '{4'h1, 6,  0, 3'd2, 8'd2, 2'd0};

    nsteps[0] = 0; nsteps[1] = 0;
    now = 0;
    key_n = 4'hF;
    do_reset();
    drive(4'hF, 6);

    // Clean press: first step 6 edges after the first low sample.
    t0 = tick_no;
    first = -1;
    key_n = 4'hA;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step0 && first < 0) first = tick_no;
    end
    check("latency", first - (t0 + 1), 6);
    check("clean_func", func0, 3'b101);
    check("clean_count", pc0, 1);
    drive(4'hF, 10);

    // Bounce and release-bounce table from a fresh reset.
    do_reset();
    for (int r = 0; r < 12; r++) begin
      s0 = nsteps[0];
      drive(tbl[r].key, tbl[r].n);
      check($sformatf("tbl%0d_steps", r), nsteps[0] - s0, tbl[r].steps);
      check($sformatf("tbl%0d_func", r), func0, tbl[r].fn);
      check($sformatf("tbl%0d_count", r), pc0, tbl[r].pc);
      check($sformatf("tbl%0d_state", r), st0, tbl[r].st);
    end

    // Auto-repeat on the REPEAT_CYCLES=8 instance.
    s0 = nsteps[0]; s1 = nsteps[1];
    gap_bad = 0;
    key_n = 4'hA;
    first = -1;
    for (int i = 0; i < 47; i++) begin
      tick();
      if (step1) begin
        if (first >= 0 && tick_no - first != R1) gap_bad++;
        first = tick_no;
      end
    end
    check("repeat_steps", nsteps[1] - s1, 6);
    check("repeat_gaps", gap_bad, 0);
    check("norepeat_steps", nsteps[0] - s0, 1);
    drive(4'hF, 10);

    // Reset while ARMING with the key still held.
    key_n = 4'hE;
    first = 0;
    for (int i = 0; i < 10 && st0 != 2'd1; i++) tick();
    check("reach_arming", st0, 1);
    do_reset();
    s0 = nsteps[0]; s1 = nsteps[1];
    drive(4'hE, 20);
    check("held_thru_reset0", nsteps[0] - s0, 0);
    check("held_thru_reset1", nsteps[1] - s1, 0);
    check("held_state", st0, 0);
    drive(4'hF, 10);
    s0 = nsteps[0];
    drive(4'hE, 10);
    check("repress_step", nsteps[0] - s0, 1);
    drive(4'hF, 10);

    // 256 presses wrap the counter to zero.
    do_reset();
    drive(4'hF, 4);
    s0 = nsteps[0]; s1 = nsteps[1];
    for (int k = 0; k < 256; k++) begin
      drive(4'hE, 8);
      drive(4'hF, 8);
    end
    check("wrap_steps0", nsteps[0] - s0, 256);
    check("wrap_steps1", nsteps[1] - s1, 256);
    check("wrap_count0", pc0, 0);
    check("wrap_count1", pc1, 0);

    // Randomized key activity against the model.
    for (int k = 0; k < 200; k++) begin
      if (k == 100) do_reset();
      drive(4'($urandom_range(0, 15)), $urandom_range(1, 12));
    end
    drive(4'hF, 12);
    check("final_state0", st0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
